// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin Req/Gnt/Ack write sequencer for one shared register.
// Define REG_SHARE_ARBITER_WRCOUNT_EN to add the 16-bit saturating WrCount output.
module reg_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*WIDTH-1:0] WrData,
    output logic [NREQ-1:0]       Gnt,
    output logic [NREQ-1:0]       Ack,
    output logic [WIDTH-1:0]      Q,
    output logic                  Busy
`ifdef REG_SHARE_ARBITER_WRCOUNT_EN
    ,
    output logic [15:0]           WrCount
`endif
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt, win, win_nxt, pick;
    logic [NREQ-1:0] gnt_nxt, ack_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic commit;
    int idx;
    // Scan from the highest offset down so the requester nearest ptr wins.
    always_comb begin
        pick = '0;
        idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (Req[IW'(idx)]) pick = IW'(idx);
        end
    end
    assign commit = (state == GRANT) && Req[win];
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        gnt_nxt   = '0;
        ack_nxt   = '0;
        q_nxt     = Q;
        case (state)
            IDLE: if (|Req) begin
                win_nxt       = pick;
                gnt_nxt[pick] = 1'b1;
                state_nxt     = GRANT;
            end
            GRANT: begin
                state_nxt = commit ? COMMIT : IDLE;
                if (commit) begin
                    q_nxt        = WrData[win*WIDTH +: WIDTH];
                    ack_nxt[win] = 1'b1;
                    ptr_nxt      = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            Gnt   <= '0;
            Ack   <= '0;
            Q     <= '0;
            Busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            win   <= win_nxt;
            Gnt   <= gnt_nxt;
            Ack   <= ack_nxt;
            Q     <= q_nxt;
            Busy  <= state_nxt != IDLE;
        end
    end
`ifdef REG_SHARE_ARBITER_WRCOUNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) WrCount <= '0;
        else if (commit && WrCount != 16'hFFFF) WrCount <= WrCount + 16'd1;
    end
`endif
endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: directed and random Req/Gnt/Ack traffic against a
// transaction-level model of the round-robin write sequencer.
module tb_reg_share_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    logic Clk = 1'b0;
    logic Reset;
    logic [N-1:0] Req = '0;
    logic [N*W-1:0] WrData = '0;
    logic [N-1:0] Gnt, Ack;
    logic [W-1:0] Q;
    logic Busy;
`ifdef REG_SHARE_ARBITER_WRCOUNT_EN
    logic [15:0] WrCount;
`endif
    int errs = 0;
    int checks = 0;
    int m_step, m_owner, m_ptr, e_cnt;
    logic [N-1:0] e_gnt, e_ack;
    logic [W-1:0] e_q, q_save;
    int acks[$];
    logic [W-1:0] qs[$];

    always #5 Clk = ~Clk;

    reg_share_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .WrData(WrData),
        .Gnt(Gnt), .Ack(Ack), .Q(Q), .Busy(Busy)
`ifdef REG_SHARE_ARBITER_WRCOUNT_EN
        , .WrCount(WrCount)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_from_ptr(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_step = 0;
        m_ptr = 0;
        e_gnt = '0;
        e_ack = '0;
        e_q = '0;
        e_cnt = 0;
    endtask

    task automatic compare(input string tag);
        check({tag, ".gnt"}, 32'(Gnt), 32'(e_gnt));
        check({tag, ".ack"}, 32'(Ack), 32'(e_ack));
        check({tag, ".q"}, 32'(Q), 32'(e_q));
        check({tag, ".busy"}, 32'(Busy), 32'(m_step != 0));
`ifdef REG_SHARE_ARBITER_WRCOUNT_EN
        check({tag, ".wrcount"}, 32'(WrCount), 32'(e_cnt));
`endif
    endtask

    // Model a write as: arbitrate (grant), then capture+ack, then one idle-return cycle.
    task automatic step(input string tag);
        e_gnt = '0;
        e_ack = '0;
        if (m_step == 0) begin
            if (Req != 0) begin
                m_owner = first_from_ptr(Req);
                e_gnt[m_owner] = 1'b1;
                m_step = 1;
            end
        end else if (m_step == 1) begin
            if (Req[m_owner]) begin
                e_q = WrData[m_owner*W +: W];
                e_ack[m_owner] = 1'b1;
                m_ptr = (m_owner + 1) % N;
                if (e_cnt < 65535) e_cnt++;
                acks.push_back(m_owner);
                qs.push_back(e_q);
                m_step = 2;
            end else m_step = 0;
        end else m_step = 0;
        @(posedge Clk);
        #1;
        compare(tag);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        #2;
        compare("reset_async");
        @(posedge Clk);
        #1;
        compare("reset_hold");
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        model_reset();
        @(posedge Clk);
        #1;
        compare("reset");
        repeat (2) begin
            @(posedge Clk);
            #1;
            compare("reset_hold");
        end
        Reset = 1'b0;

        WrData[2*W +: W] = 8'hA5;
        Req = 4'b0100;
        step("single_grant");
        check("single.gnt", 32'(Gnt), 32'h4);
        step("single_commit");
        check("single.q", 32'(Q), 32'hA5);
        check("single.ack", 32'(Ack), 32'h4);
        Req = '0;
        step("single_done");
        check("single.busy", 32'(Busy), 32'h0);

        do_reset();
        for (int i = 0; i < N; i++) WrData[i*W +: W] = W'(8'h10 + i);
        acks.delete();
        qs.delete();
        Req = 4'b1111;
        repeat (15) step("all_req");
        check("all.count", acks.size(), 5);
        for (int i = 0; i < 5 && i < acks.size(); i++) begin
            check("all.order", acks[i], i % N);
            check("all.qseq", 32'(qs[i]), 32'(8'h10 + i % N));
        end

        Req = 4'b0010;
        repeat (3) step("serve1");
        Req = '0;
        step("settle");
        acks.delete();
        Req = 4'b0011;
        repeat (6) step("wrap");
        check("wrap.first", acks.size() > 0 ? acks[0] : -1, 0);
        check("wrap.second", acks.size() > 1 ? acks[1] : -1, 1);

        Req = '0;
        step("settle");
        Req = 4'b1000;
        step("wd_grant");
        check("wd.gnt", 32'(Gnt), 32'h8);
        q_save = Q;
        Req = '0;
        step("wd_drop");
        check("wd.q", 32'(Q), 32'(q_save));
        check("wd.ack", 32'(Ack), 32'h0);
        check("wd.busy", 32'(Busy), 32'h0);
        Req = 4'b1010;
        step("wd_ptr");
        check("wd.ptr", 32'(Gnt), 32'h8);
        Req = '0;
        step("wd_drop2");

        WrData[0 +: W] = 8'h5C;
        Req = 4'b0001;
        step("mid_grant");
        check("mid.gnt", 32'(Gnt), 32'h1);
        do_reset();
        check("mid.q", 32'(Q), 32'h0);
        acks.delete();
        repeat (9) step("three_writes");
        check("three.count", acks.size(), 3);
`ifdef REG_SHARE_ARBITER_WRCOUNT_EN
        check("three.wrcount", 32'(WrCount), 32'd3);
`endif

        Req = '0;
        for (int n = 0; n < 2000; n++) begin
            step("random");
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) Req[i] = 1'($urandom_range(1));
                else if (e_gnt[i]) begin
                    if ($urandom_range(7) == 0) Req[i] = 1'b0;
                end else if (!Req[i]) begin
                    Req[i] = ($urandom_range(2) == 0);
                    WrData[i*W +: W] = W'($urandom);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
